// File: rtl/aes_dec_key_sched.sv
// AES-128 round-key source for the inverse cipher.
// A load captures the cipher key. The next ten cycles expand it into an
// 11-entry key file. The keys are then served from round 10 down to round 0,
// one per advance. After round 0 the sequence starts again at round 10, so
// further blocks under the same key do not need a new expansion.
//
//   state     | meaning
//   ST_IDLE   | no valid keys yet; waiting for a load
//   ST_EXPAND | writing rk[cnt] from rk[cnt-1]; loads and advances ignored
//   ST_SERVE  | key file complete; oRoundKey = rk[idx]

module aes_dec_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         iKeyLoad,
  input  logic [127:0] iKey,
  output logic         oLoadReady,
  output logic [127:0] oRoundKey,
  output logic [3:0]   oRoundIdx,
  output logic         oKeyValid,
  input  logic         iKeyAdv,
  output logic         oLastKey
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  // Forward AES S-box. Entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [127:0]  rk_q [0:NR];

  logic          rk_we;
  logic [3:0]    rk_waddr;
  logic [127:0]  rk_wdata;

  logic [3:0]    prev_addr;
  logic [127:0]  prev_key;
  logic [127:0]  next_key;
  logic [31:0]   rot_w, sub_w, t_w;
  logic [31:0]   nw0, nw1, nw2, nw3;
  logic [7:0]    rcon;

  // Round constant for the key currently being produced (rk[cnt]).
  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One key-expansion step: rk[cnt] is derived from rk[cnt-1].
  always_comb begin
    prev_addr = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    prev_key  = rk_q[prev_addr];
    rot_w     = {prev_key[23:0], prev_key[31:24]};
    sub_w     = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                 sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    t_w       = sub_w ^ {rcon, 24'h000000};
    nw0       = prev_key[127:96] ^ t_w;
    nw1       = prev_key[95:64]  ^ nw0;
    nw2       = prev_key[63:32]  ^ nw1;
    nw3       = prev_key[31:0]   ^ nw2;
    next_key  = {nw0, nw1, nw2, nw3};
  end

  // Next-state logic, key-file write port and index control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rk_we    = 1'b0;
    rk_waddr = cnt_q;
    rk_wdata = next_key;
    case (state_q)
      ST_IDLE, ST_SERVE: begin
        if (iKeyLoad) begin
          // A load takes priority over an advance in the same cycle.
          rk_we    = 1'b1;
          rk_waddr = 4'd0;
          rk_wdata = iKey;
          cnt_d    = 4'd1;
          state_d  = ST_EXPAND;
        end else if (state_q == ST_SERVE && iKeyAdv) begin
          idx_d = (idx_q == 4'd0) ? LAST_IDX : idx_q - 4'd1;
        end
      end
      ST_EXPAND: begin
        rk_we    = 1'b1;
        rk_waddr = cnt_q;
        rk_wdata = next_key;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = 4'd0;
          idx_d   = LAST_IDX;
          state_d = ST_SERVE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and key file. The reset is synchronous and also clears the key file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (rk_we) rk_q[rk_waddr] <= rk_wdata;
    end
  end

  // The outputs are taken only from registers.
  assign oLoadReady = (state_q != ST_EXPAND);
  assign oKeyValid  = (state_q == ST_SERVE);
  assign oRoundIdx  = idx_q;
  assign oRoundKey  = rk_q[idx_q];
  assign oLastKey   = (state_q == ST_SERVE) && (idx_q == 4'd0);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched.
// A reference model is updated on each rising edge. After each update it
// queues the outputs it expects for that cycle. A monitor takes one entry
// from the queue on each falling edge and compares it with the DUT outputs.
// The main process drives the test scenarios. It also checks the known
// FIPS-197 key values and the load-to-valid latency.

module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iKeyLoad;
  logic [127:0] iKey;
  logic         oLoadReady;
  logic [127:0] oRoundKey;
  logic [3:0]   oRoundIdx;
  logic         oKeyValid;
  logic         iKeyAdv;
  logic         oLastKey;

  aes_dec_key_sched #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iKeyLoad   (iKeyLoad),
    .iKey       (iKey),
    .oLoadReady (oLoadReady),
    .oRoundKey  (oRoundKey),
    .oRoundIdx  (oRoundIdx),
    .oKeyValid  (oKeyValid),
    .iKeyAdv    (iKeyAdv),
    .oLastKey   (oLastKey)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb_tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // The S-box is built from its definition: the GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  logic [127:0] m_pend [11];
  logic [127:0] m_keys [11];

  // Key expansion computed directly over the 44-word schedule.
  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tbl[t[31:24]], sb_tbl[t[23:16]], sb_tbl[t[15:8]], sb_tbl[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  typedef struct {
    logic         valid;
    logic         ready;
    logic         last;
    logic         chk;
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t sb_q[$];

  localparam int M_IDLE = 0, M_EXP = 1, M_SERVE = 2;
  int m_mode = M_IDLE;
  int m_idx  = 0;
  int m_busy = 0;

  // The model advances on each rising edge and queues the outputs expected for the new cycle.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_idx  = 0;
      m_busy = 0;
      for (int i = 0; i < 11; i++) m_keys[i] = '0;
    end else begin
      case (m_mode)
        M_EXP: begin
          m_busy--;
          if (m_busy == 0) begin
            for (int i = 0; i < 11; i++) m_keys[i] = m_pend[i];
            m_idx  = 10;
            m_mode = M_SERVE;
          end
        end
        default: begin
          if (iKeyLoad) begin
            expand_key(iKey);
            m_busy = 10;
            m_mode = M_EXP;
          end else if (m_mode == M_SERVE && iKeyAdv) begin
            m_idx = (m_idx + 10) % 11;
          end
        end
      endcase
    end
    e.valid = (m_mode == M_SERVE);
    e.ready = (m_mode != M_EXP);
    e.chk   = (m_mode != M_EXP);
    e.idx   = 4'(m_idx);
    e.key   = m_keys[m_idx];
    e.last  = (m_mode == M_SERVE) && (m_idx == 0);
    sb_q.push_back(e);
  end

  // The monitor takes the expected entry for this cycle and compares it with the DUT.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_valid", 128'(oKeyValid), 128'(e.valid));
      check("sb_ready", 128'(oLoadReady), 128'(e.ready));
      check("sb_last", 128'(oLastKey), 128'(e.last));
      if (e.chk) begin
        check("sb_idx", 128'(oRoundIdx), 128'(e.idx));
        check("sb_key", oRoundKey, e.key);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge. The load is sampled at the next rising edge (E0), and the task returns at the falling edge after it.
  task automatic load_key(input logic [127:0] k);
    iKeyLoad = 1'b1;
    iKey     = k;
    @(negedge clk);
    iKeyLoad = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!oKeyValid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    iKeyLoad = 1'b0;
    iKeyAdv  = 1'b0;
    iKey     = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_valid", 128'(oKeyValid), 128'(0));
    check("reset_ready", 128'(oLoadReady), 128'(1));
    check("reset_key", oRoundKey, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: FIPS-197 key, check latency and rk10.
    load_key(K1);
    wait_valid(n);
    check("s1_latency", 128'(n), 128'(10));
    check("s1_idx10", 128'(oRoundIdx), 128'(10));
    check("s1_rk10", oRoundKey, K1_RK10);

    // Scenario 2: advance continuously and wrap from round 0 to round 10.
    iKeyAdv = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check("s2_idx", 128'(oRoundIdx), 128'((21 - i) % 11));
      if (i == 9)  check("s2_rk1", oRoundKey, K1_RK1);
      if (i == 10) begin
        check("s2_rk0", oRoundKey, K1);
        check("s2_last", 128'(oLastKey), 128'(1));
      end
      if (i == 11) check("s2_wrap_rk10", oRoundKey, K1_RK10);
    end
    iKeyAdv = 1'b0;

    // Scenario 3: second key, advance asserted at random.
    load_key(K2);
    wait_valid(n);
    check("s3_latency", 128'(n), 128'(10));
    check("s3_rk10", oRoundKey, K2_RK10);
    for (int i = 0; i < 40; i++) begin
      iKeyAdv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    iKeyAdv = 1'b0;

    // Scenario 4: a load pulse in cycle E5 must be ignored.
    load_key(K1);
    repeat (4) @(negedge clk);
    iKeyLoad = 1'b1;
    iKey     = K2;
    iKeyAdv  = 1'b1;
    check("s4_ready_low", 128'(oLoadReady), 128'(0));
    @(negedge clk);
    iKeyLoad = 1'b0;
    iKeyAdv  = 1'b0;
    wait_valid(n);
    check("s4_latency_rest", 128'(n), 128'(5));
    check("s4_rk10", oRoundKey, K1_RK10);

    // Scenario 5: at idx 6, a load and an advance in the same cycle. The load takes priority.
    iKeyAdv = 1'b1;
    repeat (4) @(negedge clk);
    check("s5_idx6", 128'(oRoundIdx), 128'(6));
    iKeyLoad = 1'b1;
    iKey     = K2;
    @(negedge clk);
    iKeyLoad = 1'b0;
    iKeyAdv  = 1'b0;
    check("s5_valid_drop", 128'(oKeyValid), 128'(0));
    check("s5_idx_kept", 128'(oRoundIdx), 128'(6));
    wait_valid(n);
    check("s5_latency", 128'(n), 128'(10));
    check("s5_rk10", oRoundKey, K2_RK10);

    // Scenario 6a: reset during EXPAND, in cycle E4.
    load_key(K1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s6a_valid", 128'(oKeyValid), 128'(0));
    check("s6a_ready", 128'(oLoadReady), 128'(1));
    check("s6a_idx", 128'(oRoundIdx), 128'(0));
    check("s6a_key", oRoundKey, 128'(0));
    load_key(K1);
    wait_valid(n);
    check("s6a_latency", 128'(n), 128'(10));
    check("s6a_rk10", oRoundKey, K1_RK10);

    // Scenario 6b: reset during SERVE.
    iKeyAdv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    iKeyAdv = 1'b0;
    check("s6b_valid", 128'(oKeyValid), 128'(0));
    check("s6b_ready", 128'(oLoadReady), 128'(1));
    check("s6b_idx", 128'(oRoundIdx), 128'(0));
    check("s6b_last", 128'(oLastKey), 128'(0));
    load_key(K2);
    wait_valid(n);
    check("s6b_latency", 128'(n), 128'(10));
    check("s6b_rk10", oRoundKey, K2_RK10);
    for (int i = 0; i < 30; i++) begin
      iKeyAdv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    iKeyAdv = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_sched.md
Name: aes_dec_key_sched

Overview:
- Upstream round-key source for the AES-128 inverse round datapath. Supplies the round keys consumed on the inverse round function's iKeyValue input.
- Accepts a 128-bit cipher key and expands the 11 round keys (FIPS-197 KeyExpansion), one per cycle, into an internal register file.
- Presents the keys in reverse order (round 10 down to 0), one per consumer handshake.
- Keys are retained, so successive blocks under the same key need no re-expansion.

Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; only 10 is supported).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- iKeyLoad  input  1  load request; iKey is sampled when iKeyLoad=1 and oLoadReady=1.
- iKey  input  128  cipher key; byte 0 at [127:120]; word w0 at [127:96].
- oLoadReady  output  1  1 in IDLE and SERVE, 0 in EXPAND.
- oRoundKey  output  128  current round key rk[idx]; same byte order as iKey.
- oRoundIdx  output  4  index of the key on oRoundKey (10..0).
- oKeyValid  output  1  oRoundKey is valid (state SERVE).
- iKeyAdv  input  1  consumer advance; takes effect only when oKeyValid=1.
- oLastKey  output  1  oKeyValid=1 and oRoundIdx=0.

Behaviour:
Reset (rst_n=0 at an edge):
- state=IDLE, cnt=0, idx=0.
- oKeyValid=0, oLoadReady=1, oRoundIdx=0, oRoundKey=0, oLastKey=0.
- Register file cleared to 0.
- Reset applies regardless of state, including mid-EXPAND and mid-SERVE.

States:
- IDLE: waits for a load.
- EXPAND: oLoadReady=0; iKeyLoad and iKeyAdv are ignored.
- SERVE: oKeyValid=1.

Load (edge E0, iKeyLoad=1 with state IDLE or SERVE):
- rk[0] <= iKey; cnt <= 1; state -> EXPAND; oKeyValid -> 0 in the next cycle.
- A load in SERVE aborts serving; the old keys are overwritten.

Expansion (edges E1..E10):
- At edge Ek, rk[k] is computed from rk[k-1] and written:
  - t = SubWord(RotWord(w3)) ^ {Rcon[k],24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- SubWord uses 4 combinational forward S-box lookups; the encryption-path S-box module may be reused.
- At E10: state -> SERVE, idx <= 10.
- oKeyValid=1 and oRoundKey=rk10 are visible in the cycle after E10.
- Load-to-first-key latency: 10 cycles.

Serve:
- oRoundKey = rk[idx]; oRoundIdx = idx.
- The output mux is driven only from registers; there is no combinational path from any input to any output.
- An edge with iKeyAdv=1 decrements idx. Consecutive iKeyAdv cycles step one key per cycle.
- Wrap-around: iKeyAdv at idx=0 sets idx <= 10. The keys are reused for the next block; there is no gap cycle.

Simultaneous events:
- iKeyLoad and iKeyAdv in the same SERVE cycle: load wins and the advance is dropped.
- iKeyLoad held high during EXPAND: ignored. It is accepted at the first cycle with oLoadReady=1 if still asserted.
- iKeyAdv in IDLE or EXPAND: ignored.

Width rules:
- cnt and idx are 4 bits. Values 11..15 never occur; decrement from 0 is handled explicitly by the wrap rule.

Test Plan:
1. Reset, then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c loaded at E0:
   - oKeyValid rises exactly 10 cycles later.
   - oRoundIdx=10, oRoundKey=d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Continue scenario 1 with iKeyAdv held high:
   - Keys appear one per cycle, idx 10..0.
   - idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - idx=0 gives the cipher key with oLastKey=1.
   - The next advance returns to idx=10 with rk10 unchanged.
3. Key 000102030405060708090a0b0c0d0e0f:
   - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
   - iKeyAdv gated randomly: idx changes only on cycles with iKeyAdv=1; oRoundKey is stable otherwise.
4. iKeyLoad pulsed during EXPAND (cycle E5):
   - Ignored; oLoadReady=0; expansion of the original key completes unchanged.
5. In SERVE at idx=6, assert iKeyLoad together with iKeyAdv using a new key:
   - oKeyValid drops the next cycle and idx is not decremented.
   - The new rk10 is valid 10 cycles after the load edge.
6. rst_n=0 for one edge mid-EXPAND (cycle E4) and separately mid-SERVE:
   - All outputs return to reset values (oKeyValid=0, oLoadReady=1, oRoundIdx=0) the next cycle.
   - A subsequent load behaves as in scenario 1.
